// File: rtl/io_chan_bank.sv
// io_chan_bank: NCHAN contiguous output channels of CHW bits.
// Each channel has an edge-detected write/clear strobe with one-cycle
// acknowledges, a level read path that ORs external inputs into the data,
// and a free-running FLASH divider.
// Optional feature macro: IOCHAN_GOJAM_CLR_EN (GOJAM zeroes all channels
// and suppresses same-cycle write/clear events).
module io_chan_bank #(
    parameter int NCHAN     = 4,
    parameter int CHW       = 15,
    parameter int ADDR_W    = 9,
    parameter int CH_BASE   = 11,
    parameter int FLASH_DIV = 8,
    parameter int FLASH_ON  = 2
) (
    input  logic                  SIM_CLK,
    input  logic                  SIM_RST,
    input  logic                  GOJAM,
    input  logic [ADDR_W-1:0]     CHADDR,
    input  logic                  WCHG_n,
    input  logic                  CCHG_n,
    input  logic                  RCHG_n,
    input  logic [CHW-1:0]        WL,
    input  logic [NCHAN*CHW-1:0]  CHIN,
    output logic [CHW-1:0]        CH,
    output logic                  CH_VLD,
    output logic [NCHAN*CHW-1:0]  CHREG,
    output logic [NCHAN-1:0]      WCH_n,
    output logic [NCHAN-1:0]      CCH,
    output logic                  FLASH,
    output logic                  FLASH_n
);

    localparam int IW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int CW = $clog2(FLASH_DIV);

    logic [NCHAN-1:0][CHW-1:0] r_chreg;
    logic [NCHAN-1:0][CHW-1:0] w_chin;
    logic [NCHAN-1:0]          r_wch_n;
    logic [NCHAN-1:0]          r_cch;
    logic [CHW-1:0]            r_ch;
    logic                      r_vld;
    logic                      r_wprev;
    logic                      r_cprev;
    logic [CW-1:0]             r_cnt;
    logic                      r_flash;

    logic [31:0]               w_addr;
    logic                      w_hit;
    logic [IW-1:0]             w_idx;
    logic                      w_wev;
    logic                      w_cev;
    logic                      w_gclr;
    logic [NCHAN-1:0]          w_wsel;
    logic [NCHAN-1:0]          w_csel;

    assign w_chin = CHIN;
    assign w_addr = 32'(CHADDR);
    assign w_hit  = (w_addr >= 32'(CH_BASE)) && (w_addr < 32'(CH_BASE + NCHAN));
    assign w_idx  = IW'(w_addr - 32'(CH_BASE));

    // A held-low strobe is one event: only the high-to-low transition counts.
    assign w_wev = ~WCHG_n & r_wprev;
    assign w_cev = ~CCHG_n & r_cprev;

`ifdef IOCHAN_GOJAM_CLR_EN
    assign w_gclr = GOJAM;
`else
    logic w_gojam_unused;
    assign w_gojam_unused = GOJAM;
    assign w_gclr         = 1'b0;
`endif

    assign w_wsel = (w_wev && w_hit && !w_gclr) ? (NCHAN'(1) << w_idx) : '0;
    assign w_csel = (w_cev && w_hit && !w_gclr) ? (NCHAN'(1) << w_idx) : '0;

    // Strobe history; resets high so a strobe held through reset still fires.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            r_wprev <= 1'b1;
            r_cprev <= 1'b1;
        end else begin
            r_wprev <= WCHG_n;
            r_cprev <= CCHG_n;
        end
    end

    // Channel registers and acknowledges; restart clear beats write beats clear.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            r_chreg <= '0;
            r_wch_n <= '1;
            r_cch   <= '0;
        end else begin
            r_wch_n <= ~w_wsel;
            r_cch   <= w_csel;
            for (int i = 0; i < NCHAN; i++) begin
                if (w_gclr)
                    r_chreg[i] <= '0;
                else if (w_wsel[i])
                    r_chreg[i] <= WL;
                else if (w_csel[i])
                    r_chreg[i] <= '0;
            end
        end
    end

    // Level read: registered merge of channel contents and external inputs.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            r_ch  <= '0;
            r_vld <= 1'b0;
        end else if (!RCHG_n && w_hit) begin
            r_ch  <= r_chreg[w_idx] | w_chin[w_idx];
            r_vld <= 1'b1;
        end else begin
            r_ch  <= '0;
            r_vld <= 1'b0;
        end
    end

    // FLASH divider: high for the first FLASH_ON counts of each period.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            r_cnt   <= '0;
            r_flash <= 1'b0;
        end else begin
            r_cnt   <= (r_cnt == CW'(FLASH_DIV - 1)) ? '0 : r_cnt + CW'(1);
            r_flash <= (int'(r_cnt) < FLASH_ON);
        end
    end

    assign CHREG   = r_chreg;
    assign WCH_n   = r_wch_n;
    assign CCH     = r_cch;
    assign CH      = r_ch;
    assign CH_VLD  = r_vld;
    assign FLASH   = r_flash;
    assign FLASH_n = ~r_flash;

endmodule
